// File: rtl/dma_csr_cmd_ctrl.sv
// AXI4-Lite CSR front-end issuing single-word s2mm/mm2s commands to the DMA engine.
// Optional macro DMA_CSR_IRQ_EN: implements CTRL.IRQ_EN and the registered level interrupt.
module dma_csr_cmd_ctrl #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              s_axil_awaddr,
  input  logic                    s_axil_awvalid,
  output logic                    s_axil_awready,
  input  logic [DATA_WIDTH-1:0]   s_axil_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axil_wstrb,
  input  logic                    s_axil_wvalid,
  output logic                    s_axil_wready,
  output logic [1:0]              s_axil_bresp,
  output logic                    s_axil_bvalid,
  input  logic                    s_axil_bready,
  input  logic [7:0]              s_axil_araddr,
  input  logic                    s_axil_arvalid,
  output logic                    s_axil_arready,
  output logic [DATA_WIDTH-1:0]   s_axil_rdata,
  output logic [1:0]              s_axil_rresp,
  output logic                    s_axil_rvalid,
  input  logic                    s_axil_rready,
  output logic                    o_eng_s2mm_en,
  output logic                    o_eng_mm2s_en,
  output logic [ADDR_WIDTH-1:0]   o_eng_addr,
  output logic [DATA_WIDTH-1:0]   o_eng_wdata,
  input  logic [DATA_WIDTH-1:0]   i_eng_rdata,
  input  logic                    i_eng_done,
  input  logic [1:0]              i_eng_resp,
  output logic                    irq
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_STATUS = 8'h04;
  localparam logic [7:0] OFF_ADDR   = 8'h08;
  localparam logic [7:0] OFF_WDATA  = 8'h0C;
  localparam logic [7:0] OFF_RDATA  = 8'h10;
  localparam logic [7:0] OFF_CMDCNT = 8'h14;

  typedef enum logic [1:0] {WIDLE, WACK, WRESP} wr_state_t;
  typedef enum logic [1:0] {RIDLE, RACK, RDATA} rd_state_t;
  typedef enum logic [1:0] {C_IDLE, C_ISSUE, C_WAIT} cmd_state_t;

  wr_state_t  wr_state_reg, wr_state_next;
  rd_state_t  rd_state_reg, rd_state_next;
  cmd_state_t cmd_state_reg, cmd_state_next;

  logic [CNT_W-1:0]      wait_cnt_reg, wait_cnt_next;
  logic [DATA_WIDTH-1:0] addr_reg, addr_next, wdata_reg, wdata_next;
  logic [DATA_WIDTH-1:0] rdata_reg, cmd_cnt_reg;
  logic [DATA_WIDTH-1:0] rd_data_reg, rd_mux_data;
  logic [1:0]            bresp_reg, rresp_reg;
  logic                  done_reg, err_reg, tout_reg;
  logic                  s2mm_en_reg, mm2s_en_reg, cmd_is_rd_reg;
  logic [ADDR_WIDTH-1:0] eng_addr_reg;
  logic [DATA_WIDTH-1:0] eng_wdata_reg;
  logic                  rd_mux_err, wr_mapped, irq_en_bit;
  logic                  cmd_done, cmd_timeout;

  // The write takes effect in the single cycle awready/wready are high.
  wire wr_fire   = (wr_state_reg == WACK);
  wire wr_ctrl   = wr_fire && (s_axil_awaddr == OFF_CTRL) && s_axil_wstrb[0];
  wire wr_status = wr_fire && (s_axil_awaddr == OFF_STATUS) && s_axil_wstrb[0];
  wire start_wr  = wr_ctrl && s_axil_wdata[0];
  wire start_rd  = wr_ctrl && s_axil_wdata[1];
  wire busy      = (cmd_state_reg != C_IDLE);
  wire start_ok  = (start_wr ^ start_rd) && !busy && (addr_reg[1:0] == 2'b00);
  wire start_bad = (start_wr || start_rd) && !start_ok;

  assign wr_mapped = (s_axil_awaddr == OFF_CTRL)  || (s_axil_awaddr == OFF_STATUS) ||
                     (s_axil_awaddr == OFF_ADDR)  || (s_axil_awaddr == OFF_WDATA)  ||
                     (s_axil_awaddr == OFF_RDATA) || (s_axil_awaddr == OFF_CMDCNT);

  genvar gi;
  generate
    for (gi = 0; gi < STRB_W; gi++) begin : g_byte
      assign addr_next[8*gi +: 8] = (wr_fire && s_axil_awaddr == OFF_ADDR && s_axil_wstrb[gi]) ?
                                    s_axil_wdata[8*gi +: 8] : addr_reg[8*gi +: 8];
      assign wdata_next[8*gi +: 8] = (wr_fire && s_axil_awaddr == OFF_WDATA && s_axil_wstrb[gi]) ?
                                     s_axil_wdata[8*gi +: 8] : wdata_reg[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    wr_state_next = wr_state_reg;
    case (wr_state_reg)
      WIDLE:   if (s_axil_awvalid && s_axil_wvalid) wr_state_next = WACK;
      WACK:    wr_state_next = WRESP;
      WRESP:   if (s_axil_bready) wr_state_next = WIDLE;
      default: wr_state_next = WIDLE;
    endcase
  end

  always_comb begin
    rd_state_next = rd_state_reg;
    case (rd_state_reg)
      RIDLE:   if (s_axil_arvalid) rd_state_next = RACK;
      RACK:    rd_state_next = RDATA;
      RDATA:   if (s_axil_rready) rd_state_next = RIDLE;
      default: rd_state_next = RIDLE;
    endcase
  end

  always_comb begin
    cmd_state_next = cmd_state_reg;
    wait_cnt_next  = wait_cnt_reg;
    cmd_done       = 1'b0;
    cmd_timeout    = 1'b0;
    case (cmd_state_reg)
      C_IDLE:  if (start_ok) cmd_state_next = C_ISSUE;
      C_ISSUE: begin
        cmd_state_next = C_WAIT;
        wait_cnt_next  = '0;
      end
      C_WAIT: begin
        if (i_eng_done) begin
          cmd_done       = 1'b1;
          cmd_state_next = C_IDLE;
        end else if (wait_cnt_reg == WAIT_LAST) begin
          cmd_timeout    = 1'b1;
          cmd_state_next = C_IDLE;
        end else begin
          wait_cnt_next = wait_cnt_reg + 1'b1;
        end
      end
      default: cmd_state_next = C_IDLE;
    endcase
  end

  always_comb begin
    rd_mux_data = '0;
    rd_mux_err  = 1'b0;
    case (s_axil_araddr)
      OFF_CTRL:   rd_mux_data[2] = irq_en_bit;
      OFF_STATUS: rd_mux_data[3:0] = {tout_reg, err_reg, done_reg, busy};
      OFF_ADDR:   rd_mux_data = addr_reg;
      OFF_WDATA:  rd_mux_data = wdata_reg;
      OFF_RDATA:  rd_mux_data = rdata_reg;
      OFF_CMDCNT: rd_mux_data = cmd_cnt_reg;
      default:    rd_mux_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_state_reg  <= WIDLE;
      rd_state_reg  <= RIDLE;
      cmd_state_reg <= C_IDLE;
      wait_cnt_reg  <= '0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      rdata_reg     <= '0;
      cmd_cnt_reg   <= '0;
      rd_data_reg   <= '0;
      bresp_reg     <= 2'b00;
      rresp_reg     <= 2'b00;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
      tout_reg      <= 1'b0;
      s2mm_en_reg   <= 1'b0;
      mm2s_en_reg   <= 1'b0;
      cmd_is_rd_reg <= 1'b0;
      eng_addr_reg  <= '0;
      eng_wdata_reg <= '0;
    end else begin
      wr_state_reg  <= wr_state_next;
      rd_state_reg  <= rd_state_next;
      cmd_state_reg <= cmd_state_next;
      wait_cnt_reg  <= wait_cnt_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      if (wr_fire) bresp_reg <= wr_mapped ? 2'b00 : 2'b10;
      if (rd_state_reg == RACK) begin
        rd_data_reg <= rd_mux_data;
        rresp_reg   <= rd_mux_err ? 2'b10 : 2'b00;
      end
      // Hardware set takes priority over a same-cycle CPU W1C.
      done_reg <= (done_reg & ~(wr_status & s_axil_wdata[1])) | cmd_done;
      err_reg  <= (err_reg & ~(wr_status & s_axil_wdata[2])) | start_bad | cmd_timeout |
                  (cmd_done & (i_eng_resp != 2'b00));
      tout_reg <= (tout_reg & ~(wr_status & s_axil_wdata[3])) | cmd_timeout;
      s2mm_en_reg <= start_ok & start_wr;
      mm2s_en_reg <= start_ok & start_rd;
      if (start_ok) begin
        cmd_is_rd_reg <= start_rd;
        eng_addr_reg  <= addr_reg[ADDR_WIDTH-1:0];
        eng_wdata_reg <= wdata_reg;
      end
      if (cmd_done) begin
        cmd_cnt_reg <= cmd_cnt_reg + 1'b1;
        if (cmd_is_rd_reg) rdata_reg <= i_eng_rdata;
      end
    end
  end

`ifdef DMA_CSR_IRQ_EN
  logic irq_en_reg, irq_reg;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irq_en_reg <= 1'b0;
      irq_reg    <= 1'b0;
    end else begin
      if (wr_ctrl) irq_en_reg <= s_axil_wdata[2];
      irq_reg <= irq_en_reg & (done_reg | err_reg);
    end
  end
  assign irq        = irq_reg;
  assign irq_en_bit = irq_en_reg;
`else
  assign irq        = 1'b0;
  assign irq_en_bit = 1'b0;
`endif

  assign s_axil_awready = wr_fire;
  assign s_axil_wready  = wr_fire;
  assign s_axil_bvalid  = (wr_state_reg == WRESP);
  assign s_axil_bresp   = bresp_reg;
  assign s_axil_arready = (rd_state_reg == RACK);
  assign s_axil_rvalid  = (rd_state_reg == RDATA);
  assign s_axil_rdata   = rd_data_reg;
  assign s_axil_rresp   = rresp_reg;
  assign o_eng_s2mm_en  = s2mm_en_reg;
  assign o_eng_mm2s_en  = mm2s_en_reg;
  assign o_eng_addr     = eng_addr_reg;
  assign o_eng_wdata    = eng_wdata_reg;
endmodule

// File: tb/tb_dma_csr_cmd_ctrl.sv
// Scoreboard bench for dma_csr_cmd_ctrl: directed test-plan steps plus random CSR traffic
// checked against a register-level model; a monitor pops expectations on each DUT response.
module tb_dma_csr_cmd_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  s_axil_awaddr = '0, s_axil_araddr = '0;
  logic        s_axil_awvalid = 1'b0, s_axil_wvalid = 1'b0, s_axil_bready = 1'b0;
  logic        s_axil_arvalid = 1'b0, s_axil_rready = 1'b0;
  logic [31:0] s_axil_wdata = '0;
  logic [3:0]  s_axil_wstrb = '0;
  logic        s_axil_awready, s_axil_wready, s_axil_bvalid, s_axil_arready, s_axil_rvalid;
  logic [1:0]  s_axil_bresp, s_axil_rresp;
  logic [31:0] s_axil_rdata;
  logic        o_eng_s2mm_en, o_eng_mm2s_en, irq;
  logic [31:0] o_eng_addr, o_eng_wdata;
  logic [31:0] i_eng_rdata = 32'h5A5A_5A5A;
  logic        i_eng_done = 1'b0;
  logic [1:0]  i_eng_resp = 2'b00;

  dma_csr_cmd_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(1024)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axil_awaddr(s_axil_awaddr), .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
    .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb), .s_axil_wvalid(s_axil_wvalid),
    .s_axil_wready(s_axil_wready), .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid),
    .s_axil_bready(s_axil_bready), .s_axil_araddr(s_axil_araddr), .s_axil_arvalid(s_axil_arvalid),
    .s_axil_arready(s_axil_arready), .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
    .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
    .o_eng_s2mm_en(o_eng_s2mm_en), .o_eng_mm2s_en(o_eng_mm2s_en), .o_eng_addr(o_eng_addr),
    .o_eng_wdata(o_eng_wdata), .i_eng_rdata(i_eng_rdata), .i_eng_done(i_eng_done),
    .i_eng_resp(i_eng_resp), .irq(irq));

  always #5 clk = ~clk;

  typedef struct packed { logic rd; logic [31:0] addr; logic [31:0] wdata; } cmd_t;
  logic [1:0]  exp_b[$];
  logic [33:0] exp_r[$];
  cmd_t        exp_cmd[$];
  int n_vec = 0, n_miss = 0;

  // Register-level model of the CSR block
  logic [31:0] m_addr, m_wdata, m_rdata, m_cnt;
  logic        m_irq_en, m_busy, m_done, m_err, m_tout, m_cmd_rd;
  logic [7:0]  offs [0:10] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h20, 8'h01, 8'hFC, 8'h7E};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_addr = '0; m_wdata = '0; m_rdata = '0; m_cnt = '0;
    m_irq_en = 0; m_busy = 0; m_done = 0; m_err = 0; m_tout = 0; m_cmd_rd = 0;
  endtask

  task automatic model_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
    resp = 2'b00;
    case (a)
      8'h00: if (s[0]) begin
`ifdef DMA_CSR_IRQ_EN
        m_irq_en = d[2];
`endif
        if (d[1:0] != 2'b00) begin
          if (d[1:0] == 2'b11 || m_busy || m_addr[1:0] != 2'b00) m_err = 1;
          else begin
            m_busy = 1; m_cmd_rd = (d[1:0] == 2'b10);
            exp_cmd.push_back('{rd: m_cmd_rd, addr: m_addr, wdata: m_wdata});
          end
        end
      end
      8'h04: if (s[0]) begin
        if (d[1]) m_done = 0;
        if (d[2]) m_err = 0;
        if (d[3]) m_tout = 0;
      end
      8'h08: for (int i = 0; i < 4; i++) if (s[i]) m_addr[8*i +: 8] = d[8*i +: 8];
      8'h0C: for (int i = 0; i < 4; i++) if (s[i]) m_wdata[8*i +: 8] = d[8*i +: 8];
      8'h10, 8'h14: ;
      default: resp = 2'b10;
    endcase
  endtask

  task automatic model_read(input logic [7:0] a, output logic [33:0] e);
    case (a)
      8'h00: e = {2'b00, 29'd0, m_irq_en, 2'b00};
      8'h04: e = {2'b00, 28'd0, m_tout, m_err, m_done, m_busy};
      8'h08: e = {2'b00, m_addr};
      8'h0C: e = {2'b00, m_wdata};
      8'h10: e = {2'b00, m_rdata};
      8'h14: e = {2'b00, m_cnt};
      default: e = {2'b10, 32'd0};
    endcase
  endtask

  task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [1:0] r;
    int n;
    model_write(a, d, s, r);
    exp_b.push_back(r);
    @(posedge clk); #1;
    s_axil_awaddr = a; s_axil_wdata = d; s_axil_wstrb = s;
    s_axil_awvalid = 1; s_axil_wvalid = 1; s_axil_bready = 1'($urandom_range(0, 1));
    n = 0;
    do begin @(negedge clk); n++; end while (!(s_axil_awready && s_axil_wready) && n < 64);
    if (!(s_axil_awready && s_axil_wready)) check("aw_w_handshake_timeout", 0, 1);
    @(posedge clk); #1;
    s_axil_awvalid = 0; s_axil_wvalid = 0;
    n = 0;
    while (!s_axil_bvalid && n < 64) begin @(negedge clk); n++; end
    if (!s_axil_bvalid) check("bvalid_timeout", 0, 1);
    else if (!s_axil_bready) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      @(posedge clk); #1 s_axil_bready = 1;
      @(negedge clk);
    end
    @(posedge clk); #1 s_axil_bready = 0;
  endtask

  task automatic axi_read(input logic [7:0] a);
    logic [33:0] e;
    int n;
    model_read(a, e);
    exp_r.push_back(e);
    @(posedge clk); #1;
    s_axil_araddr = a; s_axil_arvalid = 1; s_axil_rready = 1'($urandom_range(0, 1));
    n = 0;
    do begin @(negedge clk); n++; end while (!s_axil_arready && n < 64);
    if (!s_axil_arready) check("ar_handshake_timeout", 0, 1);
    @(posedge clk); #1 s_axil_arvalid = 0;
    n = 0;
    while (!s_axil_rvalid && n < 64) begin @(negedge clk); n++; end
    if (!s_axil_rvalid) check("rvalid_timeout", 0, 1);
    else if (!s_axil_rready) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      @(posedge clk); #1 s_axil_rready = 1;
      @(negedge clk);
    end
    @(posedge clk); #1 s_axil_rready = 0;
  endtask

  task automatic eng_complete(input logic [31:0] rd, input logic [1:0] resp);
    @(posedge clk); #1;
    i_eng_done = 1; i_eng_rdata = rd; i_eng_resp = resp;
    @(posedge clk); #1;
    i_eng_done = 0; i_eng_rdata = $urandom; i_eng_resp = 2'($urandom);
    if (m_busy) begin
      m_busy = 0; m_done = 1; m_cnt = m_cnt + 1;
      if (resp != 2'b00) m_err = 1;
      if (m_cmd_rd) m_rdata = rd;
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic check_irq(input string name);
    @(negedge clk);
    check(name, {31'd0, irq}, {31'd0, m_irq_en & (m_done | m_err)});
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 rst_n = 0;
    @(posedge clk); #1 rst_n = 1;
    model_reset();
  endtask

  task automatic do_cmd();
    logic [31:0] c;
    int k;
    k = $urandom_range(0, 19);
    c = {29'd0, 1'($urandom_range(0, 1)), (k < 7) ? 2'b01 : (k < 14) ? 2'b10 : (k < 17) ? 2'b11 : 2'b00};
    axi_write(8'h00, c, ($urandom_range(0, 9) == 0) ? 4'hE : 4'hF);
    if (m_busy) begin
      repeat ($urandom_range(0, 3)) begin
        case ($urandom_range(0, 3))
          0: axi_write(8'h08, $urandom, 4'hF);
          1: axi_write(8'h0C, $urandom, 4'($urandom));
          2: axi_read(8'h04);
          default: axi_write(8'h00, {29'd0, 1'($urandom_range(0, 1)), 2'b01}, 4'hF);
        endcase
      end
      repeat ($urandom_range(1, 6)) @(posedge clk);
      eng_complete($urandom, ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
    end
  endtask

  // Monitor: every DUT response pops and checks the oldest matching expectation.
  initial begin
    logic [33:0] e;
    cmd_t c;
    forever begin
      @(negedge clk);
      if (s_axil_bvalid && s_axil_bready) begin
        if (exp_b.size() == 0) check("bresp_unexpected", 1, 0);
        else check("bresp", {30'd0, s_axil_bresp}, {30'd0, exp_b.pop_front()});
      end
      if (s_axil_rvalid && s_axil_rready) begin
        if (exp_r.size() == 0) check("rdata_unexpected", 1, 0);
        else begin
          e = exp_r.pop_front();
          check("rdata", s_axil_rdata, e[31:0]);
          check("rresp", {30'd0, s_axil_rresp}, {30'd0, e[33:32]});
        end
      end
      if (o_eng_s2mm_en || o_eng_mm2s_en) begin
        if (exp_cmd.size() == 0) check("eng_pulse_unexpected", 1, 0);
        else begin
          c = exp_cmd.pop_front();
          check("eng_dir", {30'd0, o_eng_mm2s_en, o_eng_s2mm_en}, {30'd0, c.rd, ~c.rd});
          check("eng_addr", o_eng_addr, c.addr);
          check("eng_wdata", o_eng_wdata, c.wdata);
        end
      end
    end
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {24'd0, s_axil_awready, s_axil_wready, s_axil_bvalid, s_axil_arready,
          s_axil_rvalid, o_eng_s2mm_en, o_eng_mm2s_en, irq}, 0);
    check("reset_eng_addr", o_eng_addr, 0);
    @(posedge clk); #1 rst_n = 1;
    axi_read(8'h04); axi_read(8'h14); axi_read(8'h00);

    // Write command
    axi_write(8'h08, 32'h1000_0000, 4'hF);
    axi_write(8'h0C, 32'hABCD_EF01, 4'hF);
    axi_write(8'h00, 32'h1, 4'hF);
    repeat (4) @(posedge clk);
    eng_complete(32'h1111_2222, 2'b00);
    axi_read(8'h04); axi_read(8'h14);
    // Read command
    axi_write(8'h00, 32'h2, 4'hF);
    repeat (3) @(posedge clk);
    eng_complete(32'hABCD_EF01, 2'b00);
    axi_read(8'h10); axi_read(8'h04); axi_read(8'h14);
    // Illegal starts: misaligned address, both start bits
    axi_write(8'h04, 32'h2, 4'h1);
    axi_write(8'h08, 32'h1000_0002, 4'hF);
    axi_write(8'h00, 32'h1, 4'hF);
    axi_read(8'h04);
    axi_write(8'h04, 32'h4, 4'h1);
    axi_write(8'h08, 32'h1000_0000, 4'hF);
    axi_write(8'h00, 32'h3, 4'hF);
    axi_read(8'h04);
    axi_write(8'h04, 32'hF, 4'h1);
    // Watchdog timeout, then a late done pulse
    axi_write(8'h00, 32'h1, 4'hF);
    repeat (990) @(posedge clk);
    axi_read(8'h04);
    repeat (40) @(posedge clk);
    m_busy = 0; m_err = 1; m_tout = 1;
    axi_read(8'h04);
    eng_complete(32'hDEAD_BEEF, 2'b00);
    axi_read(8'h14); axi_read(8'h04);
    axi_write(8'h04, 32'hE, 4'h1);
    // Interrupt enable and clear
    axi_write(8'h00, 32'h5, 4'hF);
    repeat (2) @(posedge clk);
    eng_complete(32'h0, 2'b00);
    check_irq("irq_after_done");
    axi_read(8'h00);
    axi_write(8'h04, 32'h2, 4'hF);
    check_irq("irq_after_clear");

    // Random traffic
    for (int it = 0; it < 250; it++) begin
      case ($urandom_range(0, 9))
        0, 1: axi_write(8'h08, ($urandom_range(0, 5) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC),
                        ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF);
        2: axi_write(8'h0C, $urandom, ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF);
        3, 4: do_cmd();
        5, 6: axi_read(offs[$urandom_range(0, 10)]);
        7: axi_write(8'h04, $urandom & 32'hF, 4'($urandom));
        8: axi_write(offs[$urandom_range(6, 10)], $urandom, 4'hF);
        default: eng_complete($urandom, 2'b00);
      endcase
      check_irq("irq_random");
    end

    // Reset while a command is outstanding
    axi_write(8'h08, 32'h2000_0000, 4'hF);
    axi_write(8'h00, 32'h2, 4'hF);
    repeat (3) @(posedge clk);
    pulse_reset();
    axi_read(8'h20); axi_read(8'h04); axi_read(8'h14); axi_read(8'h08);
    repeat (20) @(posedge clk);
    check_irq("irq_after_reset");

    repeat (4) @(posedge clk);
    check("exp_b_drained", exp_b.size(), 0);
    check("exp_r_drained", exp_r.size(), 0);
    check("exp_cmd_drained", exp_cmd.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/dma_csr_cmd_ctrl.md
Name: dma_csr_cmd_ctrl

Overview:
- AXI4-Lite CSR front-end that converts CPU register accesses into single-word command pulses for dma_s2mm_mm2s_engine.
- Drives the engine's s2mm_en/mm2s_en, address and write data. Captures the engine's read data and completion status.
- Provides busy/done/error status, a timeout watchdog, a completed-command counter and an interrupt.
- Sits directly upstream of the DMA engine, between the PS AXI-Lite bus and the engine control interface.

Parameters:
ADDR_WIDTH, 32, engine address width
DATA_WIDTH, 32, CSR and engine data width
TIMEOUT_CYCLES, 1024, maximum number of WAIT cycles before the command is aborted

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
s_axil_awaddr/awvalid/awready  in/in/out  8/1/1  AXI-Lite write address channel (byte offset)
s_axil_wdata/wstrb/wvalid/wready  in/in/in/out  32/4/1/1  AXI-Lite write data channel
s_axil_bresp/bvalid/bready  out/out/in  2/1/1  AXI-Lite write response channel
s_axil_araddr/arvalid/arready  in/in/out  8/1/1  AXI-Lite read address channel
s_axil_rdata/rresp/rvalid/rready  out/out/out/in  32/2/1/1  AXI-Lite read data channel
o_eng_s2mm_en  out  1  one-cycle write command pulse
o_eng_mm2s_en  out  1  one-cycle read command pulse
o_eng_addr  out  ADDR_WIDTH  command address, shadowed at issue
o_eng_wdata  out  DATA_WIDTH  write data, shadowed at issue
i_eng_rdata  in  DATA_WIDTH  engine read data, valid while i_eng_done is high
i_eng_done  in  1  one-cycle completion pulse from the engine
i_eng_resp  in  2  AXI response of the completed command
irq  out  1  level interrupt

Behaviour:
Register map (byte offsets):
- 0x00 CTRL: bit0 START_WR (W, self-clearing), bit1 START_RD (W, self-clearing), bit2 IRQ_EN (RW).
- 0x04 STATUS: bit0 BUSY (RO), bit1 DONE (W1C), bit2 ERR (W1C), bit3 TIMEOUT (W1C).
- 0x08 ADDR: RW.
- 0x0C WDATA: RW.
- 0x10 RDATA: RO.
- 0x14 CMD_CNT: RO, 32-bit, wraps 0xFFFFFFFF -> 0.
- Unmapped offsets: reads return 0; both reads and writes respond SLVERR. All mapped accesses respond OKAY.

AXI-Lite write FSM (WIDLE -> WRESP):
- Waits until awvalid and wvalid are both high, then asserts awready and wready for exactly one cycle.
- bvalid rises on the next cycle and is held until bready.
- No new AW/W is accepted while bvalid is high.
- wstrb is honoured per byte for ADDR and WDATA. CTRL and STATUS act only when wstrb[0]=1.

AXI-Lite read FSM (RIDLE -> RDATA):
- arready is high for one cycle on arvalid; rvalid is asserted next cycle and held until rready.
- rdata is stable while rvalid is high.

Command FSM (IDLE -> ISSUE -> WAIT -> IDLE):
- A CTRL write with exactly one START bit set, while in IDLE with ADDR[1:0]=0, moves the FSM to ISSUE in the cycle after the W handshake.
- ISSUE (one cycle):
  - Corresponding en pulse is high.
  - o_eng_addr and o_eng_wdata are loaded from ADDR and WDATA.
  - BUSY=1 from this cycle.
- WAIT, on i_eng_done:
  - RDATA <= i_eng_rdata (mm2s only).
  - ERR set if i_eng_resp != 0.
  - DONE set, CMD_CNT increments, BUSY clears on the next cycle, FSM returns to IDLE.
- WAIT timeout:
  - The wait counter reaching TIMEOUT_CYCLES-1 sets TIMEOUT and ERR; the FSM returns to IDLE and no DONE is set.
  - A later i_eng_done in IDLE is ignored.
- Illegal starts set ERR and issue nothing. Illegal means either:
  - both START bits set, or
  - misaligned ADDR, or
  - START while BUSY.
- CPU writes to ADDR/WDATA during BUSY update the registers but not o_eng_*.
- Hardware set of DONE/ERR/TIMEOUT in the same cycle as a CPU W1C: set wins.
- irq = IRQ_EN & (DONE | ERR), registered (one cycle after the status bit sets).

Reset values (synchronous, rst_n low):
- All registers, counters and FSMs return to IDLE/0.
- o_eng_* = 0, irq = 0, all ready/valid outputs = 0, bresp/rresp = 0.
- Reset during WAIT abandons the command: no en pulse is re-issued, and CMD_CNT = 0.

Optional Feature:
- DMA_CSR_IRQ_EN defined: the irq logic and the IRQ_EN bit are implemented as described above.
- Not defined: irq is tied to 0, CTRL bit2 reads 0, and writes to CTRL bit2 are ignored.

Test Plan:
- Write ADDR=0x10000000, WDATA=0xABCDEF01, CTRL=0x1; engine done 5 cycles later with resp=0 -> exactly one s2mm_en pulse with o_eng_addr=0x10000000 and o_eng_wdata=0xABCDEF01; STATUS=0x2; CMD_CNT=1.
- CTRL=0x2 with i_eng_rdata=0xABCDEF01 at done -> RDATA reads 0xABCDEF01; STATUS=0x2; CMD_CNT=2.
- ADDR=0x10000002, CTRL=0x1 -> no pulse, STATUS=0x4. Separately, CTRL=0x3 -> no pulse, STATUS=0x4.
- Issue a command and never assert done -> after 1024 cycles STATUS=0x0C and BUSY=0; a late done pulse leaves CMD_CNT unchanged.
- With IRQ_EN=1 (macro defined), complete a command -> irq=1; writing STATUS=0x2 clears DONE and irq returns to 0. With the macro undefined -> irq stays 0.
- Assert rst_n low for one cycle during WAIT -> all status registers 0, no pulse, and the read FSMs accept a new access immediately; a read of 0x20 returns SLVERR with rdata 0.
